// File: rtl/tmr_err_manager.sv
// TMR error manager: leaky per-replica error counters, resync
// request handshake and sticky fatal detection for the voters.
module tmr_err_manager #(
  parameter int N_ERR        = 1,
  parameter int CNT_W        = 8,
  parameter int THRESHOLD    = 16,
  parameter int DECAY_PERIOD = 1024,
  parameter int TOTAL_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_ERR-1:0]     err_detected_1_i,
  input  logic [N_ERR-1:0]     err_detected_2_i,
  input  logic [N_ERR-1:0]     err_detected_3_i,
  input  logic [N_ERR-1:0]     err_detected_i,
  input  logic [N_ERR-1:0]     err_corrected_i,
  input  logic                 clear_i,
  input  logic                 resync_ack_i,
  output logic                 resync_req_o,
  output logic [1:0]           resync_id_o,
  output logic [2:0]           faulty_mask_o,
  output logic                 fatal_o,
  output logic [3*CNT_W-1:0]   err_cnt_o,
  output logic [TOTAL_W-1:0]   total_err_o
);

  localparam int TW = (DECAY_PERIOD > 2) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] THR  = CNT_W'(THRESHOLD);
  localparam logic [TW-1:0]    TEND = TW'(DECAY_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, REQ, FATAL} state_t;

  state_t             state_q, state_d;
  logic [1:0]         id_q, id_d;
  logic               req_q, fatal_q;
  logic [CNT_W-1:0]   cnt_q [3];
  logic [CNT_W-1:0]   cnt_d [3];
  logic [TW-1:0]      timer_q, timer_d;
  logic [TOTAL_W-1:0] total_q, total_d;

  logic [2:0] e;
  logic [2:0] sel;
  logic       unc;
  logic       any_det;
  logic       tick;
  logic       clr;
  logic       ack_take;

  assign e       = {|err_detected_3_i, |err_detected_2_i, |err_detected_1_i};
  assign unc     = |(err_detected_i & ~err_corrected_i);
  assign any_det = |err_detected_i;
  assign tick    = ~|e && (timer_q == TEND);
  assign sel     = 3'b001 << id_q;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      faulty_mask_o[k] = (cnt_q[k] >= THR);
    end
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    clr      = 1'b0;
    ack_take = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (unc) begin
          state_d = FATAL;
        end else begin
          unique case (faulty_mask_o)
            3'b000: clr = clear_i;
            3'b001: begin state_d = REQ; id_d = 2'd0; end
            3'b010: begin state_d = REQ; id_d = 2'd1; end
            3'b100: begin state_d = REQ; id_d = 2'd2; end
            default: state_d = FATAL;
          endcase
        end
      end
      REQ: begin
        // a second faulty replica is beyond what TMR can mask
        if (unc || |(faulty_mask_o & ~sel)) begin
          state_d = FATAL;
        end else if (resync_ack_i) begin
          state_d  = IDLE;
          ack_take = 1'b1;
        end
      end
      FATAL:   state_d = FATAL;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      cnt_d[k] = cnt_q[k];
      if (clr) begin
        cnt_d[k] = '0;
      end else if (ack_take && id_q == 2'(k)) begin
        cnt_d[k] = '0;
      end else if (e[k]) begin
        if (cnt_q[k] != CMAX) cnt_d[k] = cnt_q[k] + 1'b1;
      end else if (tick && cnt_q[k] != '0) begin
        cnt_d[k] = cnt_q[k] - 1'b1;
      end
    end
  end

  always_comb begin
    timer_d = timer_q + 1'b1;
    if (clr || |e || tick) timer_d = '0;
    total_d = total_q;
    if (any_det && total_q != '1) total_d = total_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= 2'd0;
      req_q   <= 1'b0;
      fatal_q <= 1'b0;
      timer_q <= '0;
      total_q <= '0;
      for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      req_q   <= (state_d == REQ);
      fatal_q <= (state_d == FATAL);
      timer_q <= timer_d;
      total_q <= total_d;
      for (int k = 0; k < 3; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign resync_req_o = req_q;
  assign resync_id_o  = id_q;
  assign fatal_o      = fatal_q;
  assign err_cnt_o    = {cnt_q[2], cnt_q[1], cnt_q[0]};
  assign total_err_o  = total_q;

endmodule

// File: tb/tb_tmr_err_manager.sv
// Directed bench for tmr_err_manager with small counters and
// a short decay period so every boundary is reachable quickly.
module tb_tmr_err_manager;

  localparam int NE = 2;
  localparam int CW = 3;
  localparam int TWD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NE-1:0] e1, e2, e3, det, cor;
  logic          clear, ack;
  logic          req;
  logic [1:0]    id;
  logic [2:0]    mask;
  logic          fatal;
  logic [3*CW-1:0] cnt;
  logic [TWD-1:0]  total;

  int errs = 0;
  int checks = 0;

  tmr_err_manager #(
    .N_ERR(NE), .CNT_W(CW), .THRESHOLD(4),
    .DECAY_PERIOD(8), .TOTAL_W(TWD)
  ) dut (
    .clk(clk), .rst(rst),
    .err_detected_1_i(e1), .err_detected_2_i(e2),
    .err_detected_3_i(e3), .err_detected_i(det),
    .err_corrected_i(cor), .clear_i(clear),
    .resync_ack_i(ack), .resync_req_o(req),
    .resync_id_o(id), .faulty_mask_o(mask),
    .fatal_o(fatal), .err_cnt_o(cnt),
    .total_err_o(total)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    e1 = '0; e2 = '0; e3 = '0; det = '0; cor = '0;
    clear = 1'b0; ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] c(input int k);
    logic [3*CW-1:0] v;
    v = cnt;
    return 32'((v >> (k * CW)) & 9'h7);
  endfunction

  initial begin
    do_reset();
    chk("rst_req", req, 0);
    chk("rst_id", id, 0);
    chk("rst_mask", mask, 0);
    chk("rst_fatal", fatal, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_total", total, 0);

    // 1: replica 2 reaches threshold, resync handshake
    e2 = 2'b01; det = 2'b01; cor = 2'b01;
    cyc(4);
    chk("t1_cnt2", c(1), 4);
    chk("t1_mask", mask, 3'b010);
    chk("t1_req_early", req, 0);
    idle_in();
    cyc(1);
    chk("t1_req", req, 1);
    chk("t1_id", id, 1);
    cyc(2);
    chk("t1_req_hold", req, 1);
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    chk("t1_req_off", req, 0);
    chk("t1_cnt2_zero", c(1), 0);
    chk("t1_total", total, 4);
    cyc(1);
    chk("t1_idle", req, 0);

    // 2: leaky decay, restarted by an e_3 pulse
    do_reset();
    e1 = 2'b10; det = 2'b10; cor = 2'b10;
    cyc(3);
    idle_in();
    chk("t2_cnt1_3", c(0), 3);
    cyc(7);
    chk("t2_no_dec", c(0), 3);
    cyc(1);
    chk("t2_dec1", c(0), 2);
    cyc(3);
    e3 = 2'b01; det = 2'b01; cor = 2'b01;
    cyc(1);
    idle_in();
    chk("t2_cnt3", c(2), 1);
    cyc(7);
    chk("t2_restart", c(0), 2);
    cyc(1);
    chk("t2_dec2", c(0), 1);
    chk("t2_cnt3_dec", c(2), 0);
    cyc(8);
    chk("t2_dec3", c(0), 0);
    cyc(8);
    chk("t2_no_uflow", c(0), 0);
    chk("t2_no_uflow3", c(2), 0);

    // 3: two replicas faulty at once
    do_reset();
    e1 = 2'b01; e3 = 2'b01; det = 2'b01; cor = 2'b01;
    cyc(4);
    idle_in();
    chk("t3_mask", mask, 3'b101);
    chk("t3_fatal_early", fatal, 0);
    cyc(1);
    chk("t3_fatal", fatal, 1);
    chk("t3_req", req, 0);
    cyc(5);
    chk("t3_sticky", fatal, 1);
    chk("t3_req_hold", req, 0);
    do_reset();
    chk("t3_rst", fatal, 0);

    // 4a: uncorrectable error in IDLE
    det = 2'b10; cor = 2'b00;
    cyc(1);
    idle_in();
    chk("t4_idle_fatal", fatal, 1);
    // 4b: uncorrectable error beats ack in REQ
    do_reset();
    e2 = 2'b01; det = 2'b01; cor = 2'b01;
    cyc(4);
    idle_in();
    cyc(1);
    chk("t4_in_req", req, 1);
    det = 2'b01; cor = 2'b00; ack = 1'b1;
    cyc(1);
    idle_in();
    chk("t4_req_fatal", fatal, 1);
    chk("t4_req_off", req, 0);
    chk("t4_cnt2_kept", c(1), 4);

    // 5: counter and total saturation
    do_reset();
    e1 = 2'b01; det = 2'b01; cor = 2'b01;
    cyc(10);
    chk("t5_sat", c(0), 7);
    chk("t5_total", total, 10);
    chk("t5_req", req, 1);
    chk("t5_id", id, 0);
    cyc(8);
    idle_in();
    chk("t5_total_sat", total, 15);
    chk("t5_sat_hold", c(0), 7);

    // 6: clear ignored in REQ, reset mid-handshake
    do_reset();
    e2 = 2'b10; det = 2'b10; cor = 2'b10;
    cyc(4);
    idle_in();
    cyc(1);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("t6_clr_ign", c(1), 4);
    chk("t6_req", req, 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("t6_rst_req", req, 0);
    chk("t6_rst_cnt", cnt, 0);
    chk("t6_rst_fatal", fatal, 0);
    cyc(1);
    chk("t6_idle", req, 0);

    // clear honoured in IDLE, total kept
    e1 = 2'b01; det = 2'b01; cor = 2'b01;
    cyc(2);
    idle_in();
    chk("t7_cnt1", c(0), 2);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("t7_clr", c(0), 0);
    chk("t7_total", total, 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/tmr_err_manager.md
Name: tmr_err_manager

Overview:
- Consumer of the per-replica error flags produced by the configurable TMR voters in the fault-tolerant cv32e40p.
- Accumulates error evidence per replica with leaky saturating counters.
- Requests a resynchronisation of a replica that is persistently wrong, using a req/ack handshake with the recovery logic.
- Raises a sticky fatal flag when the fault exceeds what TMR can mask.

Parameters:
N_ERR, 1, width of each error-flag input vector (one bit per voter instance).
CNT_W, 8, width of each per-replica error counter.
THRESHOLD, 16, counter value at or above which a replica is declared faulty (1..2^CNT_W-1).
DECAY_PERIOD, 1024, consecutive error-free cycles per counter decrement (>=2).
TOTAL_W, 32, width of the total error-event counter.

Ports:
clk  input  1  clock, all state on rising edge.
rst  input  1  synchronous reset, active-high.
err_detected_1_i  input  N_ERR  replica 1 disagreed with the vote, per voter.
err_detected_2_i  input  N_ERR  replica 2 disagreed, per voter.
err_detected_3_i  input  N_ERR  replica 3 disagreed, per voter.
err_detected_i  input  N_ERR  any disagreement, per voter.
err_corrected_i  input  N_ERR  disagreement masked by majority, per voter.
clear_i  input  1  clears counters and decay timer (honoured in IDLE only).
resync_ack_i  input  1  recovery logic accepted the resync request.
resync_req_o  output  1  resync request, held until acked.
resync_id_o  output  2  replica to resync: 0, 1 or 2 for replicas 1..3.
faulty_mask_o  output  3  bit k set when cnt_k >= THRESHOLD.
fatal_o  output  1  uncorrectable or multi-replica fault, sticky.
err_cnt_o  output  3*CNT_W  {cnt_3, cnt_2, cnt_1}.
total_err_o  output  TOTAL_W  number of cycles with any err_detected_i bit set, saturating.

Behaviour:
- Reset (rst=1 at an edge):
  - all counters = 0, decay timer = 0, state = IDLE;
  - resync_req_o = 0, resync_id_o = 0, faulty_mask_o = 0, fatal_o = 0.
  - Reset takes effect from any state, including mid-handshake.
- Per-cycle reductions:
  - e_k = OR(err_detected_k_i);
  - unc = OR(err_detected_i & ~err_corrected_i).
- Counter cnt_k:
  - e_k=1: +1, saturating at 2^CNT_W-1.
  - else on decay tick with cnt_k>0: -1.
  - A counter never wraps.
- Decay timer:
  - Counts cycles where e_1, e_2 and e_3 are all 0.
  - Any e_k=1 resets it to 0.
  - Reaching DECAY_PERIOD-1 produces a one-cycle tick and wraps to 0.
- total_err: +1 per cycle with OR(err_detected_i)=1; saturates at all-ones.
- faulty_mask_o is combinational from the registered counters.
- FSM states: IDLE, REQ, FATAL.
- IDLE:
  - unc=1 -> FATAL.
  - Exactly one faulty_mask bit set -> REQ, resync_id_o latched to that index.
  - Two or more bits set -> FATAL.
  - clear_i=1 with no transition: all cnt_k = 0, timer = 0; total_err is kept.
- REQ:
  - resync_req_o=1; resync_id_o stable.
  - resync_ack_i=1 -> IDLE, cnt[resync_id] = 0 on the same edge (overrides an increment that cycle).
  - unc=1, or a faulty bit other than resync_id set -> FATAL (takes priority over ack).
  - clear_i is ignored.
- FATAL:
  - fatal_o=1, resync_req_o=0.
  - Counters keep counting; only rst leaves FATAL.
- Latency:
  - Error at cycle c -> cnt visible at c+1.
  - Threshold reached at c+1 -> resync_req_o=1 at c+2.
  - unc at cycle c -> fatal_o=1 at c+1.
  - Ack at cycle c -> resync_req_o=0 at c+1.
- Outputs resync_req_o, resync_id_o and fatal_o are registered.

Test Plan:
1. THRESHOLD=4: e_2 high cycles 0..3 -> cnt_2=4 at cycle 4, faulty_mask_o=3'b010, resync_req_o=1 with id=1 from cycle 5; ack at cycle 8 -> req=0 at cycle 9, cnt_2=0.
2. DECAY_PERIOD=8: cnt_1=3, then 24 error-free cycles -> cnt_1 decrements at cycles 8, 16, 24 to 0 and does not underflow; one e_3 pulse mid-run restarts the period.
3. THRESHOLD=4: e_1 and e_3 high together for 4 cycles in IDLE -> faulty_mask_o=3'b101, fatal_o=1 one cycle later, resync_req_o stays 0; fatal_o remains 1 until rst.
4. err_detected_i=1 with err_corrected_i=0 for one cycle in IDLE, and again with ack present in REQ -> fatal_o=1 next cycle; in REQ, FATAL wins over ack.
5. CNT_W=3: 10 consecutive e_1 cycles -> cnt_1 saturates at 7; total_err_o=10.
6. rst in REQ before ack -> next cycle resync_req_o=0, counters 0, state IDLE; clear_i in REQ leaves counters unchanged.
